// File: rtl/pkg_gate_guard_decodes.sv
// Register map, bit positions, channel FSM states and reset values
// shared by the gate guard and its per-channel state machines.
package pkg_gate_guard_decodes;

  localparam logic [7:0] ADDR_CONTROL  = 8'h00;
  localparam logic [7:0] ADDR_DEADTIME = 8'h04;
  localparam logic [7:0] ADDR_FILTER   = 8'h08;
  localparam logic [7:0] ADDR_STATUS   = 8'h0C;

  localparam int CTRL_EN1       = 0;
  localparam int CTRL_EN2       = 1;
  localparam int CTRL_IRQ_FAULT = 2;
  localparam int CTRL_IRQ_ST    = 3;

  localparam int STAT_FAULT = 0;
  localparam int STAT_ST1   = 1;
  localparam int STAT_ST2   = 2;
  localparam int STAT_FSYNC = 3;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_DRIVE_H = 2'd1,
    ST_DRIVE_L = 2'd2,
    ST_DEAD    = 2'd3
  } chan_state_e;

  localparam logic [3:0]  RST_CONTROL  = 4'h0;
  localparam logic [15:0] RST_DEADTIME = 16'h0808;
  localparam logic [7:0]  RST_FILTER   = 8'h03;

endpackage

// File: rtl/gate_guard_channel.sv
// One half-bridge leg: dead-time FSM with shoot-through suppression.
// Gate outputs are registered copies of the next state.
module gate_guard_channel
  import pkg_gate_guard_decodes::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_en,
  input  logic       i_force_off,
  input  logic [7:0] i_dead,
  input  logic       i_h,
  input  logic       i_l,
  output logic       o_gate_h,
  output logic       o_gate_l,
  output logic       o_st_pulse
);

  chan_state_e r_state;
  chan_state_e w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [1:0]  w_req;

  assign o_st_pulse = i_h & i_l;

  always_comb begin
    // a both-sides request is treated as no request
    w_req       = (i_h & i_l) ? 2'b00 : {i_h, i_l};
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!i_en || i_force_off) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (w_req == 2'b10)      w_state_nxt = ST_DRIVE_H;
          else if (w_req == 2'b01) w_state_nxt = ST_DRIVE_L;
        end
        ST_DRIVE_H, ST_DRIVE_L: begin
          if ((r_state == ST_DRIVE_H && w_req != 2'b10) ||
              (r_state == ST_DRIVE_L && w_req != 2'b01)) begin
            if (i_dead == 8'd0) begin
              w_state_nxt = ST_OFF;
            end else begin
              w_state_nxt = ST_DEAD;
              w_cnt_nxt   = i_dead;
            end
          end
        end
        ST_DEAD: begin
          if (r_cnt <= 8'd1) w_state_nxt = ST_OFF;
          else               w_cnt_nxt   = r_cnt - 8'd1;
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_OFF;
      r_cnt    <= 8'd0;
      o_gate_h <= 1'b0;
      o_gate_l <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      o_gate_h <= (w_state_nxt == ST_DRIVE_H);
      o_gate_l <= (w_state_nxt == ST_DRIVE_L);
    end
  end

endmodule

// File: rtl/pwm_gate_guard.sv
// Gate guard top: bus registers, fault synchronizer/filter/latch, irq,
// and two dead-time channels between the PWM block and the gate drivers.
module pwm_gate_guard
  import pkg_gate_guard_decodes::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  address_i,
  input  logic [31:0] writedata_i,
  input  logic        write_i,
  input  logic        read_i,
  input  logic        chipselect_i,
  output logic [31:0] readdata_o,
  input  logic        pwm1_h_i,
  input  logic        pwm1_l_i,
  input  logic        pwm2_h_i,
  input  logic        pwm2_l_i,
  input  logic        fault_n_i,
  output logic        gate1_h_o,
  output logic        gate1_l_o,
  output logic        gate2_h_o,
  output logic        gate2_l_o,
  output logic        irq_o
);

  logic [3:0]  r_control;
  logic [15:0] r_deadtime;
  logic [7:0]  r_filter;
  logic        r_fault_latched, r_st1, r_st2;
  logic        r_fs1, r_fs2;
  logic [7:0]  r_fcnt;
  logic        r_irq;
  logic [31:0] r_readdata;

  logic        w_wr, w_rd, w_trip, w_force_off;
  logic        w_st1_pulse, w_st2_pulse;
  logic [2:0]  w_w1c;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_wr        = write_i & chipselect_i;
  assign w_rd        = read_i & chipselect_i;
  assign w_w1c       = (w_wr && address_i == ADDR_STATUS) ? writedata_i[2:0] : 3'b000;
  assign w_trip      = r_fs2 & (r_fcnt == r_filter);
  assign w_force_off = r_fault_latched | w_trip;
  assign w_unused    = &{1'b0, writedata_i[31:16]};

  assign readdata_o  = r_readdata;
  assign irq_o       = r_irq;

  always_comb begin
    w_rdata = 32'd0;
    case (address_i)
      ADDR_CONTROL:  w_rdata = {28'd0, r_control};
      ADDR_DEADTIME: w_rdata = {16'd0, r_deadtime};
      ADDR_FILTER:   w_rdata = {24'd0, r_filter};
      ADDR_STATUS:   w_rdata = {28'd0, r_fs2, r_st2, r_st1, r_fault_latched};
      default:       w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_control       <= RST_CONTROL;
      r_deadtime      <= RST_DEADTIME;
      r_filter        <= RST_FILTER;
      r_fault_latched <= 1'b0;
      r_st1           <= 1'b0;
      r_st2           <= 1'b0;
      r_fs1           <= 1'b0;
      r_fs2           <= 1'b0;
      r_fcnt          <= 8'd0;
      r_irq           <= 1'b0;
      r_readdata      <= 32'd0;
    end else begin
      if (w_wr && address_i == ADDR_CONTROL)  r_control  <= writedata_i[3:0];
      if (w_wr && address_i == ADDR_DEADTIME) r_deadtime <= writedata_i[15:0];
      if (w_wr && address_i == ADDR_FILTER)   r_filter   <= writedata_i[7:0];
      if (w_rd) r_readdata <= w_rdata;

      r_fs1 <= ~fault_n_i;
      r_fs2 <= r_fs1;
      if (!r_fs2)               r_fcnt <= 8'd0;
      else if (r_fcnt != 8'hFF) r_fcnt <= r_fcnt + 8'd1;

      // set terms are ORed last so a same-cycle W1C never hides a new event
      r_fault_latched <= w_trip | (r_fault_latched & ~(w_w1c[STAT_FAULT] & ~r_fs2));
      r_st1           <= w_st1_pulse | (r_st1 & ~w_w1c[STAT_ST1]);
      r_st2           <= w_st2_pulse | (r_st2 & ~w_w1c[STAT_ST2]);

      r_irq <= (r_fault_latched & r_control[CTRL_IRQ_FAULT]) |
               ((r_st1 | r_st2) & r_control[CTRL_IRQ_ST]);
    end
  end

  gate_guard_channel u_ch1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_en        (r_control[CTRL_EN1]),
    .i_force_off (w_force_off),
    .i_dead      (r_deadtime[7:0]),
    .i_h         (pwm1_h_i),
    .i_l         (pwm1_l_i),
    .o_gate_h    (gate1_h_o),
    .o_gate_l    (gate1_l_o),
    .o_st_pulse  (w_st1_pulse)
  );

  gate_guard_channel u_ch2 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_en        (r_control[CTRL_EN2]),
    .i_force_off (w_force_off),
    .i_dead      (r_deadtime[15:8]),
    .i_h         (pwm2_h_i),
    .i_l         (pwm2_l_i),
    .o_gate_h    (gate2_h_o),
    .o_gate_l    (gate2_l_o),
    .o_st_pulse  (w_st2_pulse)
  );

endmodule

// File: tb/tb_pwm_gate_guard.sv
// Directed bench for pwm_gate_guard: dead time, shoot-through, disable,
// fault filter/latch and reset behaviour with hand-computed expectations.
module tb_pwm_gate_guard;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  address;
  logic [31:0] writedata;
  logic        write, read, cs;
  logic [31:0] readdata;
  logic        pwm1_h, pwm1_l, pwm2_h, pwm2_l;
  logic        fault_n;
  logic        gate1_h, gate1_l, gate2_h, gate2_l;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_gate_guard dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .address_i    (address),
    .writedata_i  (writedata),
    .write_i      (write),
    .read_i       (read),
    .chipselect_i (cs),
    .readdata_o   (readdata),
    .pwm1_h_i     (pwm1_h),
    .pwm1_l_i     (pwm1_l),
    .pwm2_h_i     (pwm2_h),
    .pwm2_l_i     (pwm2_l),
    .fault_n_i    (fault_n),
    .gate1_h_o    (gate1_h),
    .gate1_l_o    (gate1_l),
    .gate2_h_o    (gate2_h),
    .gate2_l_o    (gate2_l),
    .irq_o        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1; cs = 1'b1;
    @(negedge clk);
    write = 1'b0; cs = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    address = a; read = 1'b1; cs = 1'b1;
    @(negedge clk);
    read = 1'b0; cs = 1'b0;
    d = readdata;
  endtask

  // drive a new request and count all-off samples until the target side rises
  task automatic gap(input int ch, input logic h, input logic l, output int n_off);
    logic hit;
    n_off = 0;
    if (ch == 1) begin pwm1_h = h; pwm1_l = l; end
    else         begin pwm2_h = h; pwm2_l = l; end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ch == 1) hit = h ? gate1_h : gate1_l;
      else         hit = h ? gate2_h : gate2_l;
      if (hit) break;
      if (ch == 1 && !gate1_h && !gate1_l) n_off++;
      if (ch == 2 && !gate2_h && !gate2_l) n_off++;
    end
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    int          edges;

    rst = 1'b1; address = 8'h00; writedata = 32'd0; write = 1'b0; read = 1'b0; cs = 1'b0;
    pwm1_h = 1'b0; pwm1_l = 1'b0; pwm2_h = 1'b0; pwm2_l = 1'b0; fault_n = 1'b1;
    tick(1);
    check("rst_gates", {gate1_h, gate1_l, gate2_h, gate2_l}, 4'b0000);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", irq, 1'b0);
    rst = 1'b0;
    rd(8'h00, d); check("rst_control", d, 32'h0);
    rd(8'h04, d); check("rst_deadtime", d, 32'h0808);
    rd(8'h08, d); check("rst_filter", d, 32'h03);
    rd(8'h0C, d); check("rst_status", d, 32'h0);

    // dead time 3 on channel 1
    wr(8'h04, 32'h0803);
    wr(8'h00, 32'h1);
    pwm1_h = 1'b1; pwm1_l = 1'b0;
    tick(1); check("ch1_drive_h", gate1_h, 1'b1);
    tick(4);
    gap(1, 1'b0, 1'b1, n); check("dead3_gap", n, 4);
    check("dead3_gate_l", gate1_l, 1'b1);

    // dead time 0 both directions, then 255
    wr(8'h04, 32'h0800);
    gap(1, 1'b1, 1'b0, n); check("dead0_gap_lh", n, 1);
    gap(1, 1'b0, 1'b1, n); check("dead0_gap_hl", n, 1);
    wr(8'h04, 32'h08FF);
    gap(1, 1'b1, 1'b0, n); check("dead255_gap", n, 256);
    wr(8'h04, 32'h0802);
    gap(1, 1'b0, 1'b1, n); check("dead2_gap", n, 3);

    // shoot-through request while driving low
    wr(8'h00, 32'h9);
    pwm1_h = 1'b1; pwm1_l = 1'b1;
    tick(1); check("st_gates_off", {gate1_h, gate1_l}, 2'b00);
    pwm1_h = 1'b0; pwm1_l = 1'b0;
    tick(3);
    rd(8'h0C, d); check("st_status", d, 32'h2);
    check("st_irq", irq, 1'b1);
    wr(8'h0C, 32'h2);
    rd(8'h0C, d); check("st_w1c_status", d, 32'h0);
    check("st_w1c_irq", irq, 1'b0);

    // disable mid-DRIVE_H, then re-enable
    pwm1_h = 1'b1; pwm1_l = 1'b0;
    tick(1); check("dis_pre_h", gate1_h, 1'b1);
    wr(8'h00, 32'h8);
    tick(1); check("dis_off", gate1_h, 1'b0);
    wr(8'h00, 32'h9);
    check("reen_still_off", gate1_h, 1'b0);
    tick(1); check("reen_h", gate1_h, 1'b1);

    // fault filter 2: short pulse ignored, held low trips
    wr(8'h08, 32'h2);
    wr(8'h00, 32'hD);
    fault_n = 1'b0; tick(2); fault_n = 1'b1;
    tick(6);
    check("pulse_gate_h", gate1_h, 1'b1);
    rd(8'h0C, d); check("pulse_status", d, 32'h0);
    fault_n = 1'b0;
    edges = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      edges = i;
      if ({gate1_h, gate1_l, gate2_h, gate2_l} == 4'b0000) break;
    end
    check("trip_edges", edges, 5);
    rd(8'h0C, d); check("trip_status", d, 32'h9);
    check("trip_irq", irq, 1'b1);
    wr(8'h0C, 32'h1);
    rd(8'h0C, d); check("w1c_pin_low", d, 32'h9);
    fault_n = 1'b1;
    tick(4);
    rd(8'h0C, d); check("released_status", d, 32'h1);
    check("latched_hold_off", gate1_h, 1'b0);
    wr(8'h0C, 32'h1);
    rd(8'h0C, d); check("cleared_status", d, 32'h0);
    check("resume_h", gate1_h, 1'b1);
    check("cleared_irq", irq, 1'b0);

    // channel 2 with default dead2 = 8, unmapped access
    wr(8'h00, 32'h3);
    pwm2_h = 1'b1; pwm2_l = 1'b0;
    tick(1); check("ch2_drive_h", gate2_h, 1'b1);
    gap(2, 1'b0, 1'b1, n); check("ch2_dead8_gap", n, 9);
    wr(8'h10, 32'hFFFF);
    rd(8'h10, d); check("unmapped_read", d, 32'h0);
    rd(8'h00, d); check("control_after_unmapped", d, 32'h3);

    // reset with channel in DEAD, st2 set and fault latched
    wr(8'h00, 32'hF);
    wr(8'h04, 32'h08FF);
    pwm1_h = 1'b0; pwm1_l = 1'b1;
    tick(1); check("pre_rst_dead", {gate1_h, gate1_l}, 2'b00);
    pwm2_h = 1'b1; pwm2_l = 1'b1;
    tick(1);
    pwm2_h = 1'b0; pwm2_l = 1'b0;
    fault_n = 1'b0;
    tick(6);
    rd(8'h0C, d); check("pre_rst_status", d, 32'hD);
    check("pre_rst_irq", irq, 1'b1);
    rst = 1'b1; fault_n = 1'b1;
    tick(1);
    check("mid_rst_gates", {gate1_h, gate1_l, gate2_h, gate2_l}, 4'b0000);
    check("mid_rst_readdata", readdata, 32'd0);
    check("mid_rst_irq", irq, 1'b0);
    rst = 1'b0;
    rd(8'h00, d); check("post_rst_control", d, 32'h0);
    rd(8'h04, d); check("post_rst_deadtime", d, 32'h0808);
    rd(8'h08, d); check("post_rst_filter", d, 32'h03);
    rd(8'h0C, d); check("post_rst_status", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
